// File: rtl/vga_timing_pkg.sv
// Shared raster types and the default 640x480@60 (25 MHz pixel clock) timing constants.
// The phase order ACT -> FP -> SYNC -> BP is common to both axes.
package vga_timing_pkg;

    typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_ACT:  return PH_FP;
            PH_FP:   return PH_SYNC;
            PH_SYNC: return PH_BP;
            default: return PH_ACT;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter plus phase FSM with a per-phase down-counter; advances on adv.
// wrap is combinational (adv on the last position) so the next axis can step on the same edge.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output phase_t       phase,
    output logic         wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    logic [W-1:0] rem;

    function automatic logic [W-1:0] len_m1(input phase_t p);
        case (p)
            PH_ACT:  return W'(ACTIVE - 1);
            PH_FP:   return W'(FP - 1);
            PH_SYNC: return W'(SYNC - 1);
            default: return W'(BP - 1);
        endcase
    endfunction

    assign wrap = adv && (cnt == W'(TOTAL - 1));

    // rem expires in BP exactly when cnt hits TOTAL-1, so phase and cnt wrap together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= PH_ACT;
            rem   <= len_m1(PH_ACT);
        end else if (adv) begin
            cnt <= wrap ? '0 : cnt + W'(1);
            if (rem == '0) begin
                phase <= next_phase(phase);
                rem   <= len_m1(next_phase(phase));
            end else begin
                rem <= rem - W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_pix_gen.sv
// Free-running VGA pixel timing (x, y, hs, vs, de, line/frame start); all outputs registered, 1 clk behind counters.
// No backpressure; VGA_PIX_GEN_FRAME_CNT_EN adds the frame_cnt_o port and counter.
module vga_pix_gen
    import vga_timing_pkg::*;
#(
    parameter int   PIX_X_W     = 12,
    parameter int   PIX_Y_W     = 12,
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   FRAME_CNT_W = 8
) (
    input  logic               clk_25_i,
    input  logic               rst_i,
    output logic [PIX_X_W-1:0] pix_x_o,
    output logic [PIX_Y_W-1:0] pix_y_o,
    output logic               pix_hs_o,
    output logic               pix_vs_o,
    output logic               pix_de_o,
    output logic               line_start_o,
    output logic               frame_start_o
`ifdef VGA_PIX_GEN_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_len
        $error("vga_pix_gen: every timing length must be >= 1");
    end
    if (H_TOTAL > 2**PIX_X_W) begin : g_bad_x
        $error("vga_pix_gen: H_TOTAL does not fit in PIX_X_W");
    end
    if (V_TOTAL > 2**PIX_Y_W) begin : g_bad_y
        $error("vga_pix_gen: V_TOTAL does not fit in PIX_Y_W");
    end
    if (FRAME_CNT_W < 1) begin : g_bad_fc
        $error("vga_pix_gen: FRAME_CNT_W must be >= 1");
    end

    logic [PIX_X_W-1:0] h_cnt;
    logic [PIX_Y_W-1:0] v_cnt;
    phase_t             h_phase;
    phase_t             v_phase;
    logic               h_wrap;
    logic               v_wrap;
    logic               boot;
    logic               v_wrap_q;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (PIX_X_W)
    ) u_h (
        .clk    (clk_25_i),
        .rst    (rst_i),
        .adv    (1'b1),
        .cnt    (h_cnt),
        .phase  (h_phase),
        .wrap   (h_wrap)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (PIX_Y_W)
    ) u_v (
        .clk    (clk_25_i),
        .rst    (rst_i),
        .adv    (h_wrap),
        .cnt    (v_cnt),
        .phase  (v_phase),
        .wrap   (v_wrap)
    );

    // Counters sit at (0,0) either straight out of reset (boot) or the cycle after a vertical wrap.
    always_ff @(posedge clk_25_i or posedge rst_i) begin
        if (rst_i) begin
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            pix_de_o      <= 1'b0;
            pix_hs_o      <= ~HS_POL;
            pix_vs_o      <= ~VS_POL;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            boot          <= 1'b1;
            v_wrap_q      <= 1'b0;
        end else begin
            pix_x_o       <= h_cnt;
            pix_y_o       <= v_cnt;
            pix_de_o      <= (h_phase == PH_ACT) && (v_phase == PH_ACT);
            pix_hs_o      <= (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            pix_vs_o      <= (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            line_start_o  <= (h_cnt == '0);
            frame_start_o <= boot | v_wrap_q;
            boot          <= 1'b0;
            v_wrap_q      <= v_wrap;
        end
    end

`ifdef VGA_PIX_GEN_FRAME_CNT_EN
    // Only wrap-driven frame starts count, so the first frame after reset reads 0.
    always_ff @(posedge clk_25_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_o <= '0;
        end else if (v_wrap_q) begin
            frame_cnt_o <= frame_cnt_o + FRAME_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_pix_gen.sv
// Bench for vga_pix_gen: default mode, a small active-high mode and a medium mode, checked cycle by cycle
// against an arithmetic raster model (position from pixel index since reset release).
module tb_vga_pix_gen;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def, rst_small, rst_mid;
    logic [11:0] d_x, d_y, s_x, s_y, m_x, m_y;
    logic d_hs, d_vs, d_de, d_ls, d_fs;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic m_hs, m_vs, m_de, m_ls, m_fs;
`ifdef VGA_PIX_GEN_FRAME_CNT_EN
    logic [7:0] d_fc, m_fc;
    logic [1:0] s_fc;
`endif

    int compared   = 0;
    int mismatched = 0;
    int n_def, n_small, n_mid;

    vga_pix_gen u_def (
        .clk_25_i(clk), .rst_i(rst_def), .pix_x_o(d_x), .pix_y_o(d_y),
        .pix_hs_o(d_hs), .pix_vs_o(d_vs), .pix_de_o(d_de),
        .line_start_o(d_ls), .frame_start_o(d_fs)
`ifdef VGA_PIX_GEN_FRAME_CNT_EN
        , .frame_cnt_o(d_fc)
`endif
    );

    vga_pix_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .FRAME_CNT_W(2)
    ) u_small (
        .clk_25_i(clk), .rst_i(rst_small), .pix_x_o(s_x), .pix_y_o(s_y),
        .pix_hs_o(s_hs), .pix_vs_o(s_vs), .pix_de_o(s_de),
        .line_start_o(s_ls), .frame_start_o(s_fs)
`ifdef VGA_PIX_GEN_FRAME_CNT_EN
        , .frame_cnt_o(s_fc)
`endif
    );

    vga_pix_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(3),
        .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5)
    ) u_mid (
        .clk_25_i(clk), .rst_i(rst_mid), .pix_x_o(m_x), .pix_y_o(m_y),
        .pix_hs_o(m_hs), .pix_vs_o(m_vs), .pix_de_o(m_de),
        .line_start_o(m_ls), .frame_start_o(m_fs)
`ifdef VGA_PIX_GEN_FRAME_CNT_EN
        , .frame_cnt_o(m_fc)
`endif
    );

    // Mode 0 = default 640x480, 1 = small active-high, 2 = medium active-low.
    function automatic exp_t model(input int m, input int n);
        exp_t e;
        int ha, hf, hw, hb, va, vf, vw, vb, ht, vt, x, y;
        logic hp, vp;
        case (m)
            0: begin ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33; hp = 0; vp = 0; end
            1: begin ha = 8;   hf = 2;  hw = 2;  hb = 2;  va = 4;   vf = 1;  vw = 1; vb = 1;  hp = 1; vp = 1; end
            default: begin ha = 40; hf = 4; hw = 6; hb = 3; va = 30; vf = 3; vw = 2; vb = 5; hp = 0; vp = 0; end
        endcase
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        x = n % ht;
        y = (n / ht) % vt;
        e.x  = x;
        e.y  = y;
        e.de = (x < ha) && (y < va);
        e.hs = (x >= ha + hf && x < ha + hf + hw) ? hp : !hp;
        e.vs = (y >= va + vf && y < va + vf + vw) ? vp : !vp;
        e.ls = (x == 0);
        e.fs = (x == 0) && (y == 0);
        return e;
    endfunction

    function automatic exp_t obs(input int m);
        exp_t e;
        case (m)
            0: e = '{x: 32'(d_x), y: 32'(d_y), de: d_de, hs: d_hs, vs: d_vs, ls: d_ls, fs: d_fs};
            1: e = '{x: 32'(s_x), y: 32'(s_y), de: s_de, hs: s_hs, vs: s_vs, ls: s_ls, fs: s_fs};
            default: e = '{x: 32'(m_x), y: 32'(m_y), de: m_de, hs: m_hs, vs: m_vs, ls: m_ls, fs: m_fs};
        endcase
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b", e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs);
    endfunction

    // One sampling point per clock, on the falling edge; counts pixels of every running instance.
    task automatic tick();
        @(negedge clk);
        if (!rst_def)   n_def++;
        if (!rst_small) n_small++;
        if (!rst_mid)   n_mid++;
    endtask

    task automatic test_reset();
        exp_t o, r;
        rst_def = 1'b1; rst_small = 1'b1; rst_mid = 1'b1;
        repeat (3) tick();
        for (int m = 0; m < 3; m++) begin
            r = '0;
            r.hs = (m != 1);
            r.vs = (m != 1);
            o = obs(m);
            compared++;
            if (o !== r) begin
                mismatched++;
                $display("FAIL reset_vals inst=%0d got %s want %s", m, fmt(o), fmt(r));
            end
        end
`ifdef VGA_PIX_GEN_FRAME_CNT_EN
        compared++;
        if (d_fc !== 8'd0 || s_fc !== 2'd0 || m_fc !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_fcnt got %0d/%0d/%0d want 0", d_fc, s_fc, m_fc);
        end
`endif
        rst_def = 1'b0; rst_small = 1'b0; rst_mid = 1'b0;
        n_def = -1; n_small = -1; n_mid = -1;
        tick();
        for (int m = 0; m < 3; m++) begin
            o = obs(m);
            r = model(m, 0);
            compared++;
            if (o !== r || !o.de || !o.fs || !o.ls) begin
                mismatched++;
                $display("FAIL first_pixel inst=%0d got %s want %s", m, fmt(o), fmt(r));
            end
        end
    endtask

    task automatic test_line();
        exp_t o, e;
        int de_cnt = 0, hs_cnt = 0, hs_first = -1, last_ls = -1, ls_cnt = 0;
        while (n_def < 1600) begin
            tick();
            o = obs(0);
            e = model(0, n_def);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL line_px n=%0d got %s want %s", n_def, fmt(o), fmt(e));
            end
            if (n_def >= 800 && n_def < 1600) begin
                if (d_de) de_cnt++;
                if (!d_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(d_x);
                end
            end
            if (d_ls) begin
                ls_cnt++;
                if (last_ls >= 0) begin
                    compared++;
                    if (n_def - last_ls != 800) begin
                        mismatched++;
                        $display("FAIL line_start_gap got %0d want 800", n_def - last_ls);
                    end
                end
                last_ls = n_def;
            end
        end
        compared++;
        if (de_cnt != 640) begin mismatched++; $display("FAIL line_de_cnt got %0d want 640", de_cnt); end
        compared++;
        if (hs_cnt != 96) begin mismatched++; $display("FAIL line_hs_cnt got %0d want 96", hs_cnt); end
        compared++;
        if (hs_first != 656) begin mismatched++; $display("FAIL line_hs_start got %0d want 656", hs_first); end
        compared++;
        if (ls_cnt != 2) begin mismatched++; $display("FAIL line_start_cnt got %0d want 2", ls_cnt); end
    endtask

    task automatic test_frames();
        exp_t o, e;
        int de_f[2] = '{0, 0};
        int vs_f[2] = '{0, 0};
        int vs_x = -1, vs_y = -1, last_fs = -1, guard = 0;
        while (n_mid < 6360 && guard < 10000) begin
            tick();
            guard++;
            o = obs(2);
            e = model(2, n_mid);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL frame_px n=%0d got %s want %s", n_mid, fmt(o), fmt(e));
            end
            if (n_mid >= 2120 && n_mid < 6360) begin
                if (m_de) de_f[(n_mid - 2120) / 2120]++;
                if (!m_vs) begin
                    vs_f[(n_mid - 2120) / 2120]++;
                    if (vs_x < 0) begin vs_x = int'(m_x); vs_y = int'(m_y); end
                end
            end
            if (m_fs) begin
                if (last_fs >= 0) begin
                    compared++;
                    if (n_mid - last_fs != 2120) begin
                        mismatched++;
                        $display("FAIL frame_start_gap got %0d want 2120", n_mid - last_fs);
                    end
                end
                last_fs = n_mid;
            end
        end
        compared++;
        if (guard >= 10000) begin mismatched++; $display("FAIL frame_timeout got %0d want 6360", n_mid); end
        for (int f = 0; f < 2; f++) begin
            compared++;
            if (de_f[f] != 1200) begin mismatched++; $display("FAIL frame_de_cnt f=%0d got %0d want 1200", f, de_f[f]); end
            compared++;
            if (vs_f[f] != 106) begin mismatched++; $display("FAIL frame_vs_cnt f=%0d got %0d want 106", f, vs_f[f]); end
        end
        compared++;
        if (vs_x != 0 || vs_y != 33) begin
            mismatched++;
            $display("FAIL frame_vs_start got (%0d,%0d) want (0,33)", vs_x, vs_y);
        end
    endtask

    task automatic test_small_pol();
        exp_t o, e;
        int hs_min = 999, hs_max = -1, vs_min = 999, vs_max = -1, last_ls = -1, last_fs = -1;
        repeat (3 * 98) begin
            tick();
            o = obs(1);
            e = model(1, n_small);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL small_px n=%0d got %s want %s", n_small, fmt(o), fmt(e));
            end
            if (s_hs) begin
                if (int'(s_x) < hs_min) hs_min = int'(s_x);
                if (int'(s_x) > hs_max) hs_max = int'(s_x);
            end
            if (s_vs) begin
                if (int'(s_y) < vs_min) vs_min = int'(s_y);
                if (int'(s_y) > vs_max) vs_max = int'(s_y);
            end
            if (s_ls) begin
                if (last_ls >= 0) begin
                    compared++;
                    if (n_small - last_ls != 14) begin mismatched++; $display("FAIL small_h_total got %0d want 14", n_small - last_ls); end
                end
                last_ls = n_small;
            end
            if (s_fs) begin
                if (last_fs >= 0) begin
                    compared++;
                    if (n_small - last_fs != 98) begin mismatched++; $display("FAIL small_frame_len got %0d want 98", n_small - last_fs); end
                end
                last_fs = n_small;
            end
        end
        compared++;
        if (hs_min != 10 || hs_max != 11) begin mismatched++; $display("FAIL small_hs_range got %0d..%0d want 10..11", hs_min, hs_max); end
        compared++;
        if (vs_min != 5 || vs_max != 5) begin mismatched++; $display("FAIL small_vs_range got %0d..%0d want 5..5", vs_min, vs_max); end
    endtask

    task automatic test_async_reset();
        exp_t o, e, r;
        int target, guard, fs_seen, last_fs;
        // Default mode: hit mid-line around x=320 of an active line.
        target = int'($urandom_range(300, 340));
        guard = 0;
        while (n_def % 800 != target && guard < 1000) begin tick(); guard++; end
        compared++;
        if (guard >= 1000) begin mismatched++; $display("FAIL def_target_timeout got %0d want %0d", n_def % 800, target); end
        @(posedge clk);
        #2 rst_def = 1'b1;
        #1;
        r = '0; r.hs = 1'b1; r.vs = 1'b1;
        o = obs(0);
        compared++;
        if (o !== r) begin mismatched++; $display("FAIL def_async_rst got %s want %s", fmt(o), fmt(r)); end
        tick(); tick();
        rst_def = 1'b0;
        n_def = -1;
        while (n_def < 800) begin
            tick();
            o = obs(0);
            e = model(0, n_def);
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL def_restart n=%0d got %s want %s", n_def, fmt(o), fmt(e)); end
        end
        // Medium mode: reset near the frame centre, then a full frame must follow cleanly.
        target = 20 * 53 + int'($urandom_range(20, 30));
        guard = 0;
        while (n_mid % 2120 != target && guard < 3000) begin tick(); guard++; end
        compared++;
        if (guard >= 3000) begin mismatched++; $display("FAIL mid_target_timeout got %0d want %0d", n_mid % 2120, target); end
        @(posedge clk);
        #2 rst_mid = 1'b1;
        #1;
        o = obs(2);
        compared++;
        if (o !== r) begin mismatched++; $display("FAIL mid_async_rst got %s want %s", fmt(o), fmt(r)); end
        tick();
        rst_mid = 1'b0;
        n_mid = -1;
        fs_seen = 0;
        last_fs = -1;
        while (n_mid < 2120) begin
            tick();
            o = obs(2);
            e = model(2, n_mid);
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL mid_restart n=%0d got %s want %s", n_mid, fmt(o), fmt(e)); end
            if (m_fs) begin fs_seen++; last_fs = n_mid; end
        end
        compared++;
        if (fs_seen != 2 || last_fs != 2120) begin
            mismatched++;
            $display("FAIL mid_restart_fs got count=%0d last=%0d want count=2 last=2120", fs_seen, last_fs);
        end
    endtask

`ifdef VGA_PIX_GEN_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int tab[5] = '{0, 1, 2, 3, 0};
        int k = 0;
        @(posedge clk);
        #2 rst_small = 1'b1;
        tick();
        rst_small = 1'b0;
        n_small = -1;
        while (n_small < 5 * 98 - 1) begin
            tick();
            compared++;
            if (int'(s_fc) != (n_small / 98) % 4) begin
                mismatched++;
                $display("FAIL fcnt_steady n=%0d got %0d want %0d", n_small, s_fc, (n_small / 98) % 4);
            end
            if (s_fs) begin
                compared++;
                if (k > 4 || int'(s_fc) != tab[k]) begin
                    mismatched++;
                    $display("FAIL fcnt_seq k=%0d got %0d want %0d", k, s_fc, (k < 5) ? tab[k] : -1);
                end
                k++;
            end
        end
        compared++;
        if (k != 5) begin mismatched++; $display("FAIL fcnt_frames got %0d want 5", k); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_small_pol();
        test_async_reset();
`ifdef VGA_PIX_GEN_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
